// File: rtl/fft_stage_sequencer_if.sv
// Control bus between the FFT stage sequencer and its neighbours:
// sample source / top-level control on one side, mux-select decoder on the other.
//
// Handshake: a sample is transferred on a rising clk edge where in_valid=1
// and in_ready=1; in_valid may be dropped at any time (no hold requirement)
// and in_ready is high for the whole LOAD phase.
interface fft_stage_sequencer_if #(
  parameter int NUMSTAGES = 5
);
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic                 stall;
  logic                 ld_data;
  logic [NUMSTAGES-3:0] counter;
  logic [2:0]           stage_num;
  logic [NUMSTAGES-1:0] ld_addr;
  logic                 busy;
  logic                 done;

  // Sequencer side: drives the strobes, counters and status.
  modport master (
    input  start,
    input  in_valid,
    input  stall,
    output in_ready,
    output ld_data,
    output counter,
    output stage_num,
    output ld_addr,
    output busy,
    output done
  );

  // Source / decoder side.
  modport slave (
    output start,
    output in_valid,
    output stall,
    input  in_ready,
    input  ld_data,
    input  counter,
    input  stage_num,
    input  ld_addr,
    input  busy,
    input  done
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Sequencing FSM for the pipelined FFT datapath (N = 2^NUMSTAGES points).
// LOAD accepts N samples, RUN walks every butterfly stage with a per-stage
// iteration counter (BFLY_CYCLES clocks per step), DONE pulses once.
// Optional macro FFT_SEQ_BITREV_EN: ld_addr presents the bit-reversed load
// index so natural-order input lands in bit-reversed buffer order.
module fft_stage_sequencer #(
  parameter int NUMSTAGES   = 5,
  parameter int BFLY_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  fft_stage_sequencer_if.master     bus,
  output logic [1:0]                dbg_state_o
);

  localparam int CNT_W = NUMSTAGES - 2;
  localparam int SUB_W = (BFLY_CYCLES > 1) ? $clog2(BFLY_CYCLES) : 1;

  localparam logic [NUMSTAGES-1:0] IDX_LAST   = '1;
  localparam logic [2:0]           STAGE_LAST = 3'(NUMSTAGES - 1);
  localparam logic [SUB_W-1:0]     SUB_LAST   = SUB_W'(BFLY_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q;
  logic                 in_ready_q;
  logic                 ld_data_q;
  logic [CNT_W-1:0]     counter_q;
  logic [2:0]           stage_q;
  logic [NUMSTAGES-1:0] ld_idx_q;
  logic [SUB_W-1:0]     sub_q;
  logic                 busy_q;
  logic                 done_q;
  logic [NUMSTAGES-1:0] ld_addr_d;

  // Main FSM: state and every output are registered here so the decoder
  // downstream only ever sees clean, edge-aligned selects.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      ld_data_q  <= 1'b0;
      counter_q  <= '0;
      stage_q    <= '0;
      ld_idx_q   <= '0;
      sub_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            state_q    <= S_LOAD;
            ld_data_q  <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            ld_idx_q   <= '0;
          end
        end

        S_LOAD: begin
          // No timeout: the source may pause indefinitely between samples.
          if (bus.in_valid) begin
            if (ld_idx_q == IDX_LAST) begin
              state_q    <= S_RUN;
              ld_idx_q   <= '0;
              ld_data_q  <= 1'b0;
              in_ready_q <= 1'b0;
              counter_q  <= '0;
              stage_q    <= '0;
              sub_q      <= '0;
            end else begin
              ld_idx_q <= ld_idx_q + 1'b1;
            end
          end
        end

        S_RUN: begin
          // Stall freezes sub, counter and stage together, so a stalled
          // step resumes exactly where it stopped.
          if (!bus.stall) begin
            if (sub_q == SUB_LAST) begin
              sub_q     <= '0;
              counter_q <= counter_q + 1'b1;
              if (&counter_q) begin
                if (stage_q == STAGE_LAST) begin
                  stage_q <= '0;
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else begin
                  stage_q <= stage_q + 1'b1;
                end
              end
            end else begin
              sub_q <= sub_q + 1'b1;
            end
          end
        end

        S_DONE: begin
          // Start is deliberately not sampled here; a new transform needs
          // start asserted again once back in IDLE.
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Load address: pure rewiring of the registered index, so still glitch-free.
  always_comb begin
    ld_addr_d = '0;
`ifdef FFT_SEQ_BITREV_EN
    for (int i = 0; i < NUMSTAGES; i++) begin
      ld_addr_d[i] = ld_idx_q[NUMSTAGES-1-i];
    end
`else
    ld_addr_d = ld_idx_q;
`endif
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ld_data   = ld_data_q;
  assign bus.counter   = counter_q;
  assign bus.stage_num = stage_q;
  assign bus.ld_addr   = ld_addr_d;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed testbench for fft_stage_sequencer (default parameters, N=32).
module tb_fft_stage_sequencer;

  localparam int NS      = 5;
  localparam int N       = 32;
  localparam int RUN_LEN = 80;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  fft_stage_sequencer_if #(.NUMSTAGES(NS)) bus ();

  fft_stage_sequencer #(
    .NUMSTAGES  (NS),
    .BFLY_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] all_outs();
    return {bus.in_ready, bus.ld_data, bus.counter, bus.stage_num,
            bus.ld_addr, bus.busy, bus.done};
  endfunction

  // Expected ld_addr for a given load index.
  function automatic logic [4:0] exp_addr(input int idx);
    logic [4:0] v;
    logic [4:0] r;
    v = 5'(idx);
`ifdef FFT_SEQ_BITREV_EN
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
`else
    r = v;
`endif
    return r;
  endfunction

  // Stimulus only: start a transform and feed all N samples back to back.
  task automatic load_all();
    bus.start = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    repeat (N) step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (all_outs() !== 15'd0 || dbg_state !== 2'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d outs=%h state=%0d expected outs=0 state=0",
                 i, all_outs(), dbg_state);
      end
      step();
    end
  endtask

  // Full transform with continuous in_valid; optionally pokes start during
  // LOAD, RUN and the DONE cycle, none of which may disturb the sequence.
  task automatic run_transform(input string tag, input bit poke_start);
    bus.start = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bus.ld_data !== 1'b1 || bus.in_ready !== 1'b1 || bus.busy !== 1'b1 ||
          bus.ld_addr !== exp_addr(i)) begin
        failures++;
        $display("FAIL %s_load i=%0d ld_data=%b in_ready=%b busy=%b ld_addr=%0d expected 1 1 1 %0d",
                 tag, i, bus.ld_data, bus.in_ready, bus.busy, bus.ld_addr, exp_addr(i));
      end
      bus.start = poke_start && (i == 5 || i == 20);
      step();
    end
    bus.start = 1'b0;
    for (int r = 0; r < RUN_LEN; r++) begin
      checks++;
      if (bus.ld_data !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 ||
          bus.done !== 1'b0 || bus.ld_addr !== 5'd0 ||
          bus.stage_num !== 3'(r / 16) || bus.counter !== 3'((r / 2) % 8)) begin
        failures++;
        $display("FAIL %s_run r=%0d stage=%0d counter=%0d ld=%b rdy=%b busy=%b done=%b expected stage=%0d counter=%0d ld=0 rdy=0 busy=1 done=0",
                 tag, r, bus.stage_num, bus.counter, bus.ld_data, bus.in_ready,
                 bus.busy, bus.done, r / 16, (r / 2) % 8);
      end
      bus.start = poke_start && (r == 10 || r == 50);
      step();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.stage_num !== 3'd0 ||
        bus.counter !== 3'd0 || dbg_state !== 2'd3) begin
      failures++;
      $display("FAIL %s_done done=%b busy=%b stage=%0d counter=%0d state=%0d expected 1 1 0 0 3",
               tag, bus.done, bus.busy, bus.stage_num, bus.counter, dbg_state);
    end
    bus.start = poke_start;
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL %s_after_done done=%b busy=%b state=%0d expected 0 0 0",
               tag, bus.done, bus.busy, dbg_state);
    end
    step();
    checks++;
    if (all_outs() !== 15'd0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL %s_stays_idle outs=%h state=%0d expected outs=0 state=0",
               tag, all_outs(), dbg_state);
    end
  endtask

  task automatic test_full();
    run_transform("full", 1'b0);
  endtask

  task automatic test_start_busy();
    run_transform("start_busy", 1'b1);
  endtask

  task automatic test_gapped();
    int cyc;
    int idx;
    int k;
    cyc = 0;
    idx = 0;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.start = 1'b0;
    while (bus.ld_data === 1'b1 && cyc < 200) begin
      checks++;
      if (bus.ld_addr !== exp_addr(idx)) begin
        failures++;
        $display("FAIL gapped_addr cyc=%0d ld_addr=%0d expected %0d",
                 cyc, bus.ld_addr, exp_addr(idx));
      end
      bus.in_valid = ~bus.in_valid;
      if (bus.in_valid) idx++;
      step();
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (cyc !== 64 || idx !== 32) begin
      failures++;
      $display("FAIL gapped_len load_cycles=%0d samples=%0d expected 64 32", cyc, idx);
    end
    k = 0;
    while (bus.done !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    checks++;
    if (k !== RUN_LEN) begin
      failures++;
      $display("FAIL gapped_run run_cycles=%0d expected %0d", k, RUN_LEN);
    end
    step();
  endtask

  task automatic test_stall();
    int rr;
    int cycles;
    int stall_cnt;
    rr = 0;
    cycles = 0;
    stall_cnt = 0;
    load_all();
    while (rr < RUN_LEN && cycles < 200) begin
      checks++;
      if (bus.stage_num !== 3'(rr / 16) || bus.counter !== 3'((rr / 2) % 8) ||
          bus.done !== 1'b0 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_run cyc=%0d stage=%0d counter=%0d done=%b busy=%b expected stage=%0d counter=%0d done=0 busy=1",
                 cycles, bus.stage_num, bus.counter, bus.done, bus.busy, rr / 16, (rr / 2) % 8);
      end
      if (rr == 38 && stall_cnt < 5) begin
        bus.stall = 1'b1;
        stall_cnt++;
      end else begin
        bus.stall = 1'b0;
        rr++;
      end
      step();
      cycles++;
    end
    bus.stall = 1'b0;
    checks++;
    if (cycles !== 85 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL stall_total run_cycles=%0d done=%b expected 85 1", cycles, bus.done);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int k;
    k = 0;
    load_all();
    while (bus.stage_num !== 3'd3 && k < 200) begin
      step();
      k++;
    end
    checks++;
    if (k !== 48 || bus.counter !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid_reach cycles=%0d counter=%0d expected 48 0", k, bus.counter);
    end
    reset = 1'b1;
    step();
    checks++;
    if (all_outs() !== 15'd0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_clear outs=%h state=%0d expected outs=0 state=0",
               all_outs(), dbg_state);
    end
    reset = 1'b0;
    step();
    checks++;
    if (all_outs() !== 15'd0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_idle outs=%h state=%0d expected outs=0 state=0",
               all_outs(), dbg_state);
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    test_reset();
    test_full();
    test_gapped();
    test_stall();
    test_reset_mid();
    test_start_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
